// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and constants for the sequential divider.
//   state_t      - controller states (IDLE, CALC, FINISH), 2-bit encoding
//   DIV_N        - default operand width
//   cnt_width()  - width of the iteration counter for an N-bit divider
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int DIV_N = 8;

  // Counter runs N-1 down to 0, so $clog2(N) bits suffice for N >= 2.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem       in  N  current partial remainder (always < divisor)
//   bit_in    in  1  next dividend bit, shifted into the remainder LSB
//   divisor   in  N  divisor
//   rem_next  out N  partial remainder after the trial subtraction
//   qbit      out 1  quotient bit produced by this iteration
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_next,
  output logic         qbit
);

  // Trial value is N+1 bits wide so a set divisor MSB cannot overflow it.
  logic [N:0] trial;

  always_comb begin
    trial = {rem, bit_in};
    qbit  = (trial >= {1'b0, divisor});
    // Since rem < divisor, trial < 2*divisor and the restored result is
    // below divisor, so doing the subtraction in N bits loses nothing.
    rem_next = trial[N-1:0] - (qbit ? divisor : {N{1'b0}});
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
//   clk          in  1  clock, rising edge
//   rst          in  1  synchronous active-high reset
//   start        in  1  request a division (sampled only while not busy)
//   dividend     in  N  numerator, latched on the accepting edge
//   divisor      in  N  denominator, latched on the accepting edge
//   busy         out 1  division in progress (CALC and FINISH)
//   done         out 1  one-cycle result-valid pulse
//   quotient     out N  dividend / divisor (all ones on divide by zero)
//   remainder    out N  dividend % divisor (dividend on divide by zero)
//   div_by_zero  out 1  last result was a divide by zero
// Optional: define SEQ_DIVIDER_CHECK_EN to compile in simulation assertions.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_t        state_reg;
  logic [N-1:0]  rem_reg;
  logic [N-1:0]  shift_reg;     // dividend bits out at MSB, quotient bits in at LSB
  logic [N-1:0]  divisor_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          dbz_reg;
  logic [N-1:0]  quotient_reg;
  logic [N-1:0]  remainder_reg;

  logic [N-1:0]  rem_next;
  logic          qbit_next;

  div_step #(.N(N)) u_step (
    .rem      (rem_reg),
    .bit_in   (shift_reg[N-1]),
    .divisor  (divisor_reg),
    .rem_next (rem_next),
    .qbit     (qbit_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rem_reg       <= '0;
      shift_reg     <= '0;
      divisor_reg   <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            divisor_reg <= divisor;
            busy_reg    <= 1'b1;
            if (divisor == '0) begin
              // Result is known immediately; publish it on this edge.
              state_reg     <= FINISH;
              done_reg      <= 1'b1;
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= dividend;
            end else begin
              state_reg <= CALC;
              rem_reg   <= '0;
              shift_reg <= dividend;
              cnt_reg   <= CW'(N - 1);
            end
          end
        end
        CALC: begin
          rem_reg   <= rem_next;
          shift_reg <= {shift_reg[N-2:0], qbit_next};
          cnt_reg   <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_reg     <= FINISH;
            done_reg      <= 1'b1;
            dbz_reg       <= 1'b0;
            quotient_reg  <= {shift_reg[N-2:0], qbit_next};
            remainder_reg <= rem_next;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

`ifdef SEQ_DIVIDER_CHECK_EN
  // Shadow copy of the accepted dividend, used only by the checks below.
  logic [N-1:0] dividend_chk_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_chk_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      dividend_chk_reg <= dividend;
    end
  end

  a_result_ok: assert property (@(posedge clk) disable iff (rst)
    (done && !div_by_zero) |->
      (({{N{1'b0}}, quotient} * {{N{1'b0}}, divisor_reg} + {{N{1'b0}}, remainder})
         == {{N{1'b0}}, dividend_chk_reg}) && (remainder < divisor_reg));

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    done |=> !done);

  a_operands_stable: assert property (@(posedge clk) disable iff (rst)
    (busy && start) |=> ($stable(divisor_reg) && $stable(dividend_chk_reg)));
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomised checks of seq_divider (N = 8).
module tb_seq_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] prev_q;
  logic [N-1:0] prev_r;
  logic         prev_dz;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called just after a clock edge with the DUT idle. Start is driven for
  // cycle 0; inj > 0 pulses a competing start (50/5) in that cycle number.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input int inj);
    int lat;
    int exp_lat;
    bit busy_ok;
    bit hold_ok;
    exp_lat = edz ? 1 : N + 1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = 0;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      // Operands are don't-care after acceptance; scramble them.
      dividend = N'($urandom);
      divisor  = N'($urandom);
      start    = 1'b0;
      if (inj != 0 && lat == inj) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done !== 1'b1 &&
          (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_dz))
        hold_ok = 1'b0;
    end while (done !== 1'b1 && lat < 40);
    start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_during", busy_ok, 1);
    chk("outputs_held", hold_ok, 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    $display("txn %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", a, b, quotient, remainder,
             div_by_zero, lat);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    bit saw_done;
    logic [N-1:0] a, b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    prev_q   = '0;
    prev_r   = '0;
    prev_dz  = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0);
    run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0);
    run_div(8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 0);
    run_div(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 0);
    run_div(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 0);
    run_div(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 4);
    run_div(8'd255, 8'd128, 8'd1, 8'd127, 1'b0, 0);
    run_div(8'd0, 8'd255, 8'd0, 8'd0, 1'b0, 0);

    // Abort a division with reset in cycle 5.
    dividend = 8'd255;
    divisor  = 8'd255;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    $display("txn 255 / 255 aborted by reset");
    rst      = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    prev_q  = '0;
    prev_r  = '0;
    prev_dz = 1'b0;
    run_div(8'd128, 8'd200, 8'd0, 8'd128, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'd0;
        1:       a = 8'd255;
        default: a = N'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       b = 8'd0;
        1:       b = 8'd255;
        2:       b = 8'd1;
        default: b = N'($urandom);
      endcase
      if (b == 0) run_div(a, b, 8'd255, a, 1'b1, 0);
      else        run_div(a, b, a / b, a % b, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse of the team's combinational array multiplier.
- Produces quotient and remainder of two N-bit operands, one quotient bit per clock.
- Sits in the same arithmetic datapath. Uses a start/done handshake so the datapath can issue a division and collect the result.
- Results satisfy dividend = quotient*divisor + remainder, checkable against the multiplier.

Parameters:
- N, 8, operand width in bits; must be >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  N  numerator, sampled on the accepting edge.
- divisor  input  N  denominator, sampled on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse: result valid.
- quotient  output  N  dividend / divisor, integer, unsigned.
- remainder  output  N  dividend % divisor, unsigned.
- div_by_zero  output  1  high with done when divisor was 0; held with the result.

Behaviour:
- Reset: all of the following are 0 on the first edge with rst=1: busy, done, quotient, remainder, div_by_zero. Internal state goes to IDLE. Reset wins over any other event, including mid-calculation; the aborted division produces no done.
- States:
  - IDLE: start=1 latches dividend and divisor.
    - Divisor == 0: go to FINISH.
    - Otherwise: go to CALC, partial remainder = 0, shift register = dividend, bit counter = N-1.
  - CALC: each cycle:
    - trial = {partial_rem[N-1:0], msb(shift)} as an N+1-bit value.
    - If trial >= divisor: partial_rem = trial - divisor and quotient bit = 1. Else partial_rem = trial and quotient bit = 0.
    - Shift the quotient bit in at the LSB. Decrement the counter.
    - After the counter=0 iteration, go to FINISH.
  - FINISH: drive done=1 for exactly one cycle, then go to IDLE.
    - Normal result: quotient/remainder registered from the datapath.
    - Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
- Latency with start high in cycle 0 (accepting edge at end of cycle 0):
  - Normal: busy=1 in cycles 1..N+1; done=1 in cycle N+1.
  - Divide-by-zero: busy=1 in cycle 1, done=1 in cycle 1.
- busy covers CALC and FINISH. start is ignored while busy=1, so no queueing. start in the cycle after done is accepted normally.
- quotient, remainder and div_by_zero hold their last values until the next done. They do not change during a new calculation. div_by_zero clears on the next normal done.
- Inputs are don't-care except on the accepting edge.
- Widths: the partial remainder datapath is N+1 bits to avoid overflow when the divisor MSB is set. Outputs are truncated to N bits, which is lossless.

Optional Feature:
- Macro: SEQ_DIVIDER_CHECK_EN.
- When defined, simulation-only concurrent assertions are compiled in:
  - On done with div_by_zero=0: quotient*divisor + remainder == latched dividend, and remainder < divisor.
  - done is never high for two consecutive cycles.
  - start while busy does not change the latched operands.
- When undefined, no assertion code is present and the RTL is identical otherwise.

Decomposition:
- Package seq_divider_pkg:
  - State enum typedef (IDLE, CALC, FINISH), 2-bit.
  - Default width constant DIV_N = 8.
  - Function for the counter width, $clog2(N).
- Sub-module div_step (combinational, parameter N):
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - The top-level holds the FSM, counter and registers.

Test Plan:
- 100/7, start pulse in cycle 0 -> done only in cycle 9 (N=8); quotient=14, remainder=2, div_by_zero=0; busy high in cycles 1..9.
- 255/1 then 5/10 back-to-back, with the second start in the cycle after the first done -> 255 r0, then 0 r5; both done pulses one cycle wide.
- 200/0 -> done in cycle 1; quotient=255, remainder=200, div_by_zero=1. A following 9/3 -> 3 r0 with div_by_zero cleared.
- 200/3 started; start with 50/5 pulsed in cycle 4 -> ignored; result 66 r2; outputs held until the next done.
- 255/255 started, rst asserted in cycle 5 -> all outputs 0 next cycle, no done. After rst is released, 128/200 -> 0 r128.
- 200 random operand pairs including 0 and 255 extremes -> each result matches the reference model (a/b, a%b); zero divisors follow the divide-by-zero rule.
